mode_sequencer: RTL and testbench
=================================

MODE_SEQUENCER -- requirements
Module: mode_sequencer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning the consecutive stable cycles required to accept a key or switch change (minimum 1).
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 4, meaning the number of cycles LEDs are blanked on a mode change (minimum 1).
REQ-003 The block SHALL have parameter TICK_DIV, default 8, meaning the clk cycles per tick pulse (minimum 2).
REQ-004 The block SHALL have input clk, 1 bit: system clock, all logic on its rising edge.
REQ-005 The block SHALL have input rst, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have input key, 4 bits: raw asynchronous push-keys.
REQ-007 The block SHALL have input sw_mode, 3 bits: raw asynchronous mode switches.
REQ-008 The block SHALL have output en, 8 bits: one-hot mode enable.
REQ-009 The block SHALL have output mode, 3 bits: active mode index.
REQ-010 The block SHALL have output mod_rst, 1 bit: one-cycle reset pulse to mode datapaths.
REQ-011 The block SHALL have output led_blank, 1 bit: forces the LED bus off.
REQ-012 The block SHALL have output key_pulse, 4 bits: one-cycle debounced rising-edge pulses.
REQ-013 The block SHALL have output tick, 1 bit: one-cycle clock-enable pulse for animated modes.

Function
REQ-014 key and sw_mode SHALL each pass through a 2-flop synchronizer.
REQ-015 Each key bit SHALL be debounced independently: the debounced value updates only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any intermediate match restarts the count.
REQ-016 sw_mode SHALL be debounced as one 3-bit group: any bit change restarts the count.
REQ-017 Latency from a clean raw key rise to key_pulse SHALL be DEBOUNCE_CYCLES+3 rising edges; the pulse SHALL last exactly 1 cycle; releases SHALL produce no pulse.
REQ-018 The FSM SHALL have states BLANK, LOAD and RUN.
REQ-019 In BLANK: en=0, led_blank=1, key_pulse=0 and tick=0; the blank counter counts to BLANK_CYCLES, then the FSM goes to LOAD.
REQ-020 In LOAD (1 cycle): mode <= debounced sw_mode, mod_rst=1, en=0, led_blank=1, tick prescaler cleared; the FSM then goes to RUN.
REQ-021 In RUN: en = 1<<mode, led_blank=0, key_pulse passes through, and tick pulses when the prescaler reaches TICK_DIV-1, so the first tick comes TICK_DIV cycles after entering RUN.
REQ-022 In RUN, if debounced sw_mode != mode, the FSM SHALL go to BLANK next cycle with the blank counter cleared.
REQ-023 A key_pulse coinciding with the mode-change detection cycle SHALL be suppressed.
REQ-024 A mode change during BLANK SHALL NOT restart BLANK; LOAD samples the latest debounced value.
REQ-025 A change landing in the LOAD cycle SHALL be caught by RUN per REQ-022.
REQ-026 The prescaler SHALL wrap from TICK_DIV-1 to 0 and count only in RUN.
REQ-027 en SHALL always be zero or one-hot, never multi-hot.

Reset
REQ-028 With rst=1 at a clock edge, the block SHALL force state=BLANK, all counters=0, mode=0, en=0, led_blank=1, mod_rst=1, key_pulse=0 and tick=0.
REQ-029 The synchronizers and debounced values SHALL reset to 0.
REQ-030 Reset mid-RUN or mid-BLANK SHALL discard the pending operation; after release, the normal BLANK->LOAD->RUN sequence SHALL follow.

Structure
REQ-031 Package mode_seq_pkg SHALL hold the state enum (BLANK/LOAD/RUN), MODE_W=3, NUM_MODES=8 and KEY_N=4.
REQ-032 Sub-module debouncer (params WIDTH, CYCLES; clk, rst, d, q) SHALL contain the synchronizer and the counter, and SHALL be instantiated once per key bit and once for sw_mode (WIDTH=3).

Verification (DEBOUNCE_CYCLES=4, BLANK_CYCLES=4, TICK_DIV=8)
REQ-033 Release rst with sw_mode=3'b010 held -> after the debounce interval, the bench SHALL see 4 cycles of BLANK, 1 cycle of LOAD with mod_rst=1, then en=8'b0000_0100, mode=2, led_blank=0, and the first tick 8 cycles later followed by a tick every 8 cycles.
REQ-034 In RUN, hold key[1] high cleanly -> key_pulse=4'b0010 for exactly 1 cycle, 7 edges after the rise; releasing the key -> no pulse.
REQ-035 Toggle key[0] every 2 cycles for 20 cycles, then leave it low -> no key_pulse.
REQ-036 In RUN mode 2, switch sw_mode to 5 -> en=0 and led_blank=1 for 5 cycles (BLANK+LOAD), then en=8'b0010_0000; a key pulse in the detection cycle -> suppressed.
REQ-037 Change sw_mode 2->5->6 with each value held stable inside BLANK -> exactly one BLANK period and final mode=6.
REQ-038 Assert rst for 1 cycle in RUN -> next cycle en=0, mode=0, tick=0, led_blank=1; the bench SHALL then see the full BLANK/LOAD/RUN sequence.

Source files
------------

// File: rtl/mode_seq_pkg.sv
// Purpose: shared types and sizes for the mode sequencer block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mode_seq_pkg;

  localparam int MODE_W    = 3;
  localparam int NUM_MODES = 8;
  localparam int KEY_N     = 4;

  typedef enum logic [1:0] {
    BLANK = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/debouncer.sv
// Purpose: 2-flop synchronizer plus a group debouncer for a WIDTH-bit raw input.
// Latency: q follows a clean change of d after CYCLES+2 rising edges.
// Backpressure: none; free-running filter.
//
// Ports: clk, rst (sync, active-high), d (raw async input), q (debounced value).
// The whole WIDTH-bit vector is treated as one group: q only takes a new value
// after sync2 has held that same value, different from q, for CYCLES edges.
module debouncer #(
  parameter int WIDTH  = 1,
  parameter int CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] last;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;

  // Length of the current run of identical synchronized samples that differ
  // from q. Matching q, or moving to another differing value, restarts it.
  always_comb begin
    cnt_next = '0;
    if (sync2 == q) begin
      cnt_next = '0;
    end else if (sync2 != last) begin
      cnt_next = CW'(1);
    end else begin
      cnt_next = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      last  <= '0;
      q     <= '0;
      cnt   <= '0;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
      last  <= sync2;
      if ((sync2 != q) && (cnt_next == CW'(CYCLES))) begin
        q   <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt_next;
      end
    end
  end

endmodule

// File: rtl/mode_sequencer.sv
// Purpose: selects one of eight mode datapaths from debounced switches, blanking
//          the LEDs and pulsing mod_rst across every mode change.
// Latency: key rise -> key_pulse in DEBOUNCE_CYCLES+3 edges; switch change ->
//          new en after debounce, one detect cycle, BLANK_CYCLES and one LOAD.
// Backpressure: none; all outputs are pulses/levels with no handshake.
//
// Ports: clk, rst (sync, active-high), key[3:0] and sw_mode[2:0] (raw async),
// en (one-hot enable), mode (active index), mod_rst (datapath reset pulse),
// led_blank (LED bus off), key_pulse (debounced rising edges), tick (prescaled
// clock enable for animated modes).
module mode_sequencer
  import mode_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BLANK_CYCLES    = 4,
  parameter int TICK_DIV        = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [KEY_N-1:0]     key,
  input  logic [MODE_W-1:0]    sw_mode,
  output logic [NUM_MODES-1:0] en,
  output logic [MODE_W-1:0]    mode,
  output logic                 mod_rst,
  output logic                 led_blank,
  output logic [KEY_N-1:0]     key_pulse,
  output logic                 tick
);

  localparam int BW = $clog2(BLANK_CYCLES + 1);
  localparam int PW = $clog2(TICK_DIV);

  logic [KEY_N-1:0]  key_db;
  logic [KEY_N-1:0]  key_db_d;
  logic [KEY_N-1:0]  key_rise_q;
  logic [MODE_W-1:0] sw_db;

  state_t            state_q;
  state_t            state_d;
  logic [BW-1:0]     blank_cnt_q;
  logic [BW-1:0]     blank_cnt_d;
  logic [PW-1:0]     presc_q;
  logic [PW-1:0]     presc_d;
  logic [MODE_W-1:0] mode_q;
  logic [MODE_W-1:0] mode_d;
  logic              rst_flag_q;

  // Keys are filtered bit by bit so one bouncing key cannot hold up another.
  for (genvar i = 0; i < KEY_N; i++) begin : g_key_db
    debouncer #(
      .WIDTH  (1),
      .CYCLES (DEBOUNCE_CYCLES)
    ) u_key_db (
      .clk (clk),
      .rst (rst),
      .d   (key[i]),
      .q   (key_db[i])
    );
  end

  // Switches are filtered as one group so a partially moved selector never
  // produces an intermediate mode.
  debouncer #(
    .WIDTH  (MODE_W),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_db (
    .clk (clk),
    .rst (rst),
    .d   (sw_mode),
    .q   (sw_db)
  );

  assign mode = mode_q;

  always_comb begin
    state_d     = state_q;
    blank_cnt_d = blank_cnt_q;
    presc_d     = presc_q;
    mode_d      = mode_q;
    en          = '0;
    led_blank   = 1'b1;
    tick        = 1'b0;
    key_pulse   = '0;
    // Held for the cycle after a reset edge so datapaths see a reset too.
    mod_rst     = rst_flag_q;

    case (state_q)
      BLANK: begin
        if (blank_cnt_q == BW'(BLANK_CYCLES - 1)) begin
          state_d     = LOAD;
          blank_cnt_d = '0;
        end else begin
          blank_cnt_d = blank_cnt_q + 1'b1;
        end
      end

      LOAD: begin
        mod_rst = 1'b1;
        mode_d  = sw_db;
        presc_d = '0;
        state_d = RUN;
      end

      RUN: begin
        led_blank   = 1'b0;
        en[mode_q]  = 1'b1;
        if (presc_q == PW'(TICK_DIV - 1)) begin
          tick    = 1'b1;
          presc_d = '0;
        end else begin
          presc_d = presc_q + 1'b1;
        end
        // A key edge arriving with a pending mode change belongs to the old
        // mode's datapath, which is about to be torn down: drop it.
        if (sw_db != mode_q) begin
          state_d     = BLANK;
          blank_cnt_d = '0;
        end else begin
          key_pulse = key_rise_q;
        end
      end

      default: begin
        state_d     = BLANK;
        blank_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= BLANK;
      blank_cnt_q <= '0;
      presc_q     <= '0;
      mode_q      <= '0;
      rst_flag_q  <= 1'b1;
      key_db_d    <= '0;
      key_rise_q  <= '0;
    end else begin
      state_q     <= state_d;
      blank_cnt_q <= blank_cnt_d;
      presc_q     <= presc_d;
      mode_q      <= mode_d;
      rst_flag_q  <= 1'b0;
      key_db_d    <= key_db;
      key_rise_q  <= key_db & ~key_db_d;
    end
  end

endmodule

// File: tb/tb_mode_sequencer.sv
// Purpose: self-checking bench for mode_sequencer against a behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mode_sequencer;

  localparam int D  = 4;
  localparam int B  = 4;
  localparam int TD = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key;
  logic [2:0] sw_mode;
  logic [7:0] en;
  logic [2:0] mode;
  logic       mod_rst;
  logic       led_blank;
  logic [3:0] key_pulse;
  logic       tick;

  always #5 clk = ~clk;

  mode_sequencer #(
    .DEBOUNCE_CYCLES (D),
    .BLANK_CYCLES    (B),
    .TICK_DIV        (TD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .sw_mode   (sw_mode),
    .en        (en),
    .mode      (mode),
    .mod_rst   (mod_rst),
    .led_blank (led_blank),
    .key_pulse (key_pulse),
    .tick      (tick)
  );

  int n_chk = 0;
  int n_err = 0;
  int pulse_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: the block is in one of three phases; a debounced value
  // is accepted once the last D synchronized samples agree and differ from it.
  int         m_phase = 0;      // 0 blank, 1 load, 2 run
  int         m_blank_spent = 0;
  int         m_run_age = 0;
  logic [2:0] m_mode = '0;
  bit         m_rst_flag = 1'b1;
  logic [3:0] m_key_db = '0;
  logic [3:0] m_key_dly = '0;
  logic [3:0] m_rise = '0;
  logic [2:0] m_sw_db = '0;
  logic [6:0] pipe[$];          // raw samples still in flight through the synchronizer
  logic [6:0] hist[$];          // most recent D synchronized samples

  task automatic model_edge();
    logic [6:0] raw;
    logic [6:0] smp;
    logic [2:0] swdb_old;
    bit         agree;
    raw = {sw_mode, key};
    if (rst) begin
      m_phase = 0; m_blank_spent = 0; m_run_age = 0; m_mode = '0;
      m_rst_flag = 1'b1; m_key_db = '0; m_key_dly = '0; m_rise = '0; m_sw_db = '0;
      pipe.delete(); pipe.push_back('0); pipe.push_back('0);
      hist.delete();
      return;
    end
    m_rst_flag = 1'b0;
    swdb_old = m_sw_db;
    case (m_phase)
      0: begin
        m_blank_spent++;
        if (m_blank_spent == B) m_phase = 1;
      end
      1: begin
        m_mode = swdb_old;
        m_phase = 2;
        m_run_age = 0;
      end
      default: begin
        if (swdb_old != m_mode) begin
          m_phase = 0;
          m_blank_spent = 0;
        end else begin
          m_run_age++;
        end
      end
    endcase
    m_rise = m_key_db & ~m_key_dly;
    m_key_dly = m_key_db;
    smp = pipe.pop_front();
    pipe.push_back(raw);
    hist.push_back(smp);
    if (hist.size() > D) void'(hist.pop_front());
    if (hist.size() == D) begin
      for (int i = 0; i < 4; i++) begin
        agree = 1'b1;
        foreach (hist[j]) if (hist[j][i] != smp[i]) agree = 1'b0;
        if (agree) m_key_db[i] = smp[i];
      end
      agree = 1'b1;
      foreach (hist[j]) if (hist[j][6:4] != smp[6:4]) agree = 1'b0;
      if (agree) m_sw_db = smp[6:4];
    end
  endtask

  task automatic check_outputs();
    logic [7:0] e_en;
    logic [3:0] e_kp;
    e_en = '0;
    if (m_phase == 2) e_en[m_mode] = 1'b1;
    e_kp = (m_phase == 2 && m_sw_db == m_mode) ? m_rise : 4'd0;
    chk("en", en, e_en);
    chk("mode", mode, m_mode);
    chk("mod_rst", mod_rst, (m_phase == 1) || m_rst_flag);
    chk("led_blank", led_blank, m_phase != 2);
    chk("key_pulse", key_pulse, e_kp);
    chk("tick", tick, (m_phase == 2) && ((m_run_age % TD) == TD - 1));
    chk("en_onehot", $countones(en) <= 1, 1);
    if (key_pulse != 4'd0) pulse_cnt++;
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
    end
  endtask

  initial begin
    rst = 1'b1;
    key = 4'd0;
    sw_mode = 3'd2;
    cyc(3);
    chk("rst_en", en, 8'd0);
    chk("rst_blank", led_blank, 1'b1);

    // Power-up with mode 2 selected.
    rst = 1'b0;
    cyc(40);
    chk("boot_en", en, 8'b0000_0100);
    chk("boot_mode", mode, 3'd2);

    // Clean press and release of key[1].
    pulse_cnt = 0;
    key[1] = 1'b1;
    cyc(15);
    chk("press_pulses", pulse_cnt, 1);
    pulse_cnt = 0;
    key[1] = 1'b0;
    cyc(15);
    chk("release_pulses", pulse_cnt, 0);

    // Bouncing key[0] never settles long enough.
    pulse_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      key[0] = ~key[0];
      cyc(2);
    end
    key[0] = 1'b0;
    cyc(10);
    chk("bounce_pulses", pulse_cnt, 0);

    // Mode change to 5 with a key edge landing in the detection cycle.
    pulse_cnt = 0;
    key[2] = 1'b1;
    cyc(1);
    sw_mode = 3'd5;
    cyc(30);
    chk("suppressed_pulses", pulse_cnt, 0);
    chk("mode5_en", en, 8'b0010_0000);
    key[2] = 1'b0;
    cyc(15);

    // Back to 2, then 5 followed by 6 while blanked.
    sw_mode = 3'd2;
    cyc(30);
    sw_mode = 3'd5;
    cyc(D + 3);
    sw_mode = 3'd6;
    cyc(40);
    chk("final_mode6", mode, 3'd6);

    // One-cycle reset in RUN.
    rst = 1'b1;
    cyc(1);
    chk("midrst_en", en, 8'd0);
    chk("midrst_mode", mode, 3'd0);
    chk("midrst_tick", tick, 1'b0);
    rst = 1'b0;
    cyc(40);
    chk("after_rst_mode", mode, 3'd6);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(7) == 0) key[$urandom_range(3)] ^= 1'b1;
      if ($urandom_range(59) == 0) sw_mode = 3'($urandom_range(7));
      rst = ($urandom_range(399) == 0);
      cyc(1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
